// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers register-write requests and drains one per cycle into the register bank.
// Optional build macro WBQ_XZR_DROP_EN: writes to register 31 are accepted but silently discarded.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int n     = 63,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [n:0]    in_data,
    input  logic          wb_stall,
    output logic          RegWrite,
    output logic [4:0]    WriteRegister,
    output logic [n:0]    WriteData,
    input  logic [4:0]    fwd_reg,
    output logic          fwd_hit,
    output logic [n:0]    fwd_data,
    output logic [AW:0]   q_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [4:0]  XZR        = 5'd31;

    logic [4:0]    r_regQ  [DEPTH];
    logic [n:0]    r_dataQ [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_regWrite;
    logic [4:0]    r_writeRegister;
    logic [n:0]    r_writeData;

    logic          w_push;
    logic          w_store;
    logic          w_pop;
    logic          w_fwdHit;
    logic [n:0]    w_fwdData;

    assign in_ready = (r_count < FULL_COUNT);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !wb_stall;

`ifdef WBQ_XZR_DROP_EN
    assign w_store  = w_push && (in_reg != XZR);
`else
    assign w_store  = w_push;
`endif

    // Entry storage carries no reset: validity is tracked purely by the count.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_regQ[r_wrPtr]  <= in_reg;
            r_dataQ[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage feeding the bank; index and data hold when nothing is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regWrite      <= 1'b0;
            r_writeRegister <= '0;
            r_writeData     <= '0;
        end else if (w_pop) begin
            r_regWrite      <= 1'b1;
            r_writeRegister <= r_regQ[r_rdPtr];
            r_writeData     <= r_dataQ[r_rdPtr];
        end else begin
            r_regWrite      <= 1'b0;
        end
    end

    // Scan oldest to youngest so that a later match overrides an earlier one.
    always_comb begin
        logic [AW-1:0] slot;
        w_fwdHit  = 1'b0;
        w_fwdData = '0;
        slot      = '0;
        if (r_regWrite && (r_writeRegister == fwd_reg)) begin
            w_fwdHit  = 1'b1;
            w_fwdData = r_writeData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = r_rdPtr + i[AW-1:0];
            if ((i[AW:0] < r_count) && (r_regQ[slot] == fwd_reg)) begin
                w_fwdHit  = 1'b1;
                w_fwdData = r_dataQ[slot];
            end
        end
`ifdef WBQ_XZR_DROP_EN
        if (fwd_reg == XZR) begin
            w_fwdHit  = 1'b0;
            w_fwdData = '0;
        end
`endif
    end

    assign RegWrite      = r_regWrite;
    assign WriteRegister = r_writeRegister;
    assign WriteData     = r_writeData;
    assign fwd_hit       = w_fwdHit;
    assign fwd_data      = w_fwdData;
    assign q_count       = r_count;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue: reset, latency, fill/stall, forwarding, steady push+pop, XZR handling.
module tb_wb_write_queue;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inReg;
    logic [63:0] inData;
    logic        wbStall;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [63:0] writeData;
    logic [4:0]  fwdReg;
    logic        fwdHit;
    logic [63:0] fwdData;
    logic [2:0]  qCount;

    int compCount;
    int failCount;

    logic [4:0]  expRegQ[$];
    logic [63:0] expDataQ[$];

    wb_write_queue #(.DEPTH(4), .n(63), .AW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (inValid),
        .in_ready      (inReady),
        .in_reg        (inReg),
        .in_data       (inData),
        .wb_stall      (wbStall),
        .RegWrite      (regWrite),
        .WriteRegister (writeRegister),
        .WriteData     (writeData),
        .fwd_reg       (fwdReg),
        .fwd_hit       (fwdHit),
        .fwd_data      (fwdData),
        .q_count       (qCount)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where outputs are sampled and inputs changed
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] r, input logic [63:0] d, input logic stall);
        inValid = valid;
        inReg   = r;
        inData  = d;
        wbStall = stall;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [63:0] rnd;
        logic [4:0]  popReg;
        logic [63:0] popData;
        compCount = 0;
        failCount = 0;
        rst       = 1'b1;
        fwdReg    = 5'd0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        #1;
        checkOutput("reset_regwrite", {63'd0, regWrite}, 64'd0);
        checkOutput("reset_count", {61'd0, qCount}, 64'd0);
        checkOutput("reset_wreg", {59'd0, writeRegister}, 64'd0);
        checkOutput("reset_wdata", writeData, 64'd0);
        checkOutput("reset_ready", {63'd0, inReady}, 64'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single write: visible on the bank port one edge after acceptance, for one cycle
        $display("[TB] single write");
        applyStimulus(1'b1, 5'd5, 64'hA5, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("single_count_after_accept", {61'd0, qCount}, 64'd1);
        checkOutput("single_no_bypass", {63'd0, regWrite}, 64'd0);
        fwdReg = 5'd5;
        #1;
        checkOutput("single_fwd_queue_hit", {63'd0, fwdHit}, 64'd1);
        checkOutput("single_fwd_queue_data", fwdData, 64'hA5);
        tick();
        checkOutput("single_regwrite", {63'd0, regWrite}, 64'd1);
        checkOutput("single_wreg", {59'd0, writeRegister}, 64'd5);
        checkOutput("single_wdata", writeData, 64'hA5);
        checkOutput("single_count_drained", {61'd0, qCount}, 64'd0);
        checkOutput("single_fwd_outstage_hit", {63'd0, fwdHit}, 64'd1);
        tick();
        checkOutput("single_regwrite_drop", {63'd0, regWrite}, 64'd0);
        checkOutput("single_wreg_hold", {59'd0, writeRegister}, 64'd5);
        checkOutput("single_fwd_gone", {63'd0, fwdHit}, 64'd0);
        checkOutput("single_fwd_gone_data", fwdData, 64'd0);

        // Fill under stall, refuse a fifth push, then drain in order
        $display("[TB] fill and drain");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'(i), 64'(16 + i), 1'b1);
            tick();
        end
        checkOutput("fill_count", {61'd0, qCount}, 64'd4);
        checkOutput("fill_ready", {63'd0, inReady}, 64'd0);
        checkOutput("fill_stall_no_write", {63'd0, regWrite}, 64'd0);
        applyStimulus(1'b1, 5'd9, 64'h99, 1'b1);
        tick();
        checkOutput("fill_refused_count", {61'd0, qCount}, 64'd4);
        fwdReg = 5'd3;
        #1;
        checkOutput("fill_fwd_hit", {63'd0, fwdHit}, 64'd1);
        checkOutput("fill_fwd_data", fwdData, 64'd19);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("drain_regwrite", {63'd0, regWrite}, 64'd1);
            checkOutput("drain_wreg", {59'd0, writeRegister}, 64'(i));
            checkOutput("drain_wdata", writeData, 64'(16 + i));
        end
        tick();
        checkOutput("drain_idle", {63'd0, regWrite}, 64'd0);
        checkOutput("drain_count", {61'd0, qCount}, 64'd0);

        // Youngest pending write to the same register wins the forward
        $display("[TB] forwarding");
        fwdReg = 5'd7;
        applyStimulus(1'b1, 5'd7, 64'd1, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd7, 64'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1);
        #1;
        checkOutput("fwd_two_hit", {63'd0, fwdHit}, 64'd1);
        checkOutput("fwd_two_data", fwdData, 64'd2);
        wbStall = 1'b0;
        tick();
        checkOutput("fwd_first_out_wdata", writeData, 64'd1);
        checkOutput("fwd_queue_over_outstage", fwdData, 64'd2);
        tick();
        checkOutput("fwd_second_out_wdata", writeData, 64'd2);
        checkOutput("fwd_outstage_hit", {63'd0, fwdHit}, 64'd1);
        checkOutput("fwd_outstage_data", fwdData, 64'd2);
        tick();
        checkOutput("fwd_drained_hit", {63'd0, fwdHit}, 64'd0);
        checkOutput("fwd_drained_data", fwdData, 64'd0);

        // Steady-state push+pop at occupancy two across pointer wrap
        $display("[TB] steady push+pop");
        fwdReg = 5'd0;
        applyStimulus(1'b1, 5'd10, 64'hAAAA_0001, 1'b1);
        expRegQ.push_back(5'd10);
        expDataQ.push_back(64'hAAAA_0001);
        tick();
        applyStimulus(1'b1, 5'd11, 64'hBBBB_0002, 1'b1);
        expRegQ.push_back(5'd11);
        expDataQ.push_back(64'hBBBB_0002);
        tick();
        checkOutput("steady_prefill_count", {61'd0, qCount}, 64'd2);
        for (int k = 0; k < 20; k++) begin
            rnd = {$urandom, $urandom};
            applyStimulus(1'b1, 5'(8 + (k % 16)), rnd, 1'b0);
            expRegQ.push_back(5'(8 + (k % 16)));
            expDataQ.push_back(rnd);
            tick();
            popReg  = expRegQ.pop_front();
            popData = expDataQ.pop_front();
            checkOutput("steady_regwrite", {63'd0, regWrite}, 64'd1);
            checkOutput("steady_wreg", {59'd0, writeRegister}, {59'd0, popReg});
            checkOutput("steady_wdata", writeData, popData);
            checkOutput("steady_count", {61'd0, qCount}, 64'd2);
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            popReg  = expRegQ.pop_front();
            popData = expDataQ.pop_front();
            checkOutput("steady_tail_wreg", {59'd0, writeRegister}, {59'd0, popReg});
            checkOutput("steady_tail_wdata", writeData, popData);
        end
        tick();
        checkOutput("steady_end_idle", {63'd0, regWrite}, 64'd0);
        checkOutput("steady_end_count", {61'd0, qCount}, 64'd0);

        // Register 31 handling depends on the drop option
        $display("[TB] register 31");
        fwdReg = 5'd31;
        applyStimulus(1'b1, 5'd31, 64'hFF, 1'b0);
        #1;
        checkOutput("xzr_ready", {63'd0, inReady}, 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
`ifdef WBQ_XZR_DROP_EN
        checkOutput("xzr_drop_count", {61'd0, qCount}, 64'd0);
        checkOutput("xzr_drop_fwd", {63'd0, fwdHit}, 64'd0);
        tick();
        checkOutput("xzr_drop_no_write", {63'd0, regWrite}, 64'd0);
`else
        checkOutput("xzr_keep_count", {61'd0, qCount}, 64'd1);
        checkOutput("xzr_keep_fwd", {63'd0, fwdHit}, 64'd1);
        tick();
        checkOutput("xzr_keep_regwrite", {63'd0, regWrite}, 64'd1);
        checkOutput("xzr_keep_wreg", {59'd0, writeRegister}, 64'd31);
        checkOutput("xzr_keep_wdata", writeData, 64'hFF);
`endif
        tick();
        fwdReg = 5'd0;

        // Reset mid-burst: pending writes vanish immediately and never reach the bank
        $display("[TB] reset mid-burst");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 64'(100 + i), 1'b1);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        checkOutput("midburst_regwrite_before", {63'd0, regWrite}, 64'd1);
        checkOutput("midburst_count_before", {61'd0, qCount}, 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midburst_regwrite_reset", {63'd0, regWrite}, 64'd0);
        checkOutput("midburst_count_reset", {61'd0, qCount}, 64'd0);
        checkOutput("midburst_wdata_reset", writeData, 64'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("midburst_no_write", {63'd0, regWrite}, 64'd0);
        end
        checkOutput("midburst_final_count", {61'd0, qCount}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
